lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_scheduler_if.sv | 33 +++
 rtl/lif_scheduler.sv | 151 +++++++++++++++
 tb/tb_lif_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lif_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lif_scheduler_if
// Brief    : Write/start/readout/spike bundle of the time-multiplexed LIF scheduler.
// Revision : 1.0
// ============================================================================
interface lif_scheduler_if #(
    parameter int N_NEURONS = 4
) ();
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 spike_valid;
    logic [3:0]           spike_id;
    logic [N_NEURONS-1:0] spike_vec;
    logic [3:0]           rd_addr;
    logic [7:0]           rd_state;
    logic [7:0]           tstep;

    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr,
        input  busy, done, spike_valid, spike_id, spike_vec, rd_state, tstep
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr,
        output busy, done, spike_valid, spike_id, spike_vec, rd_state, tstep
    );
endinterface
`default_nettype wire

// File: rtl/lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_scheduler
// Brief    : Time-multiplexed leaky integrate-and-fire neuron array, one
//            neuron updated per clock while a timestep is in progress.
// Revision : 1.0
// ============================================================================
module lif_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int THRESHOLD  = 200,
    parameter int BETA_SHIFT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    lif_scheduler_if.slave   bus
);

    localparam logic [7:0] c_THRESH = 8'(THRESHOLD);
    localparam logic [3:0] c_LAST   = 4'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } fsm_t;

    fsm_t                 fsm_q, fsm_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [7:0]           mem_q [N_NEURONS];
    logic [7:0]           mem_d [N_NEURONS];
    logic [7:0]           cur_q [N_NEURONS];
    logic [7:0]           cur_d [N_NEURONS];
    logic [N_NEURONS-1:0] shadow_q, shadow_d;
    logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [7:0]           tstep_q, tstep_d;

    logic       w_fire;
    logic [7:0] w_mem_sel;
    logic [7:0] w_cur_sel;
    logic [8:0] w_leak_sum;
    logic [7:0] w_mem_new;
    logic [7:0] w_rd_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            ptr_q       <= '0;
            shadow_q    <= '0;
            spike_vec_q <= '0;
            tstep_q     <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            fsm_q       <= fsm_d;
            ptr_q       <= ptr_d;
            shadow_q    <= shadow_d;
            spike_vec_q <= spike_vec_d;
            tstep_q     <= tstep_d;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= mem_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        shadow_d    = shadow_q;
        spike_vec_d = spike_vec_q;
        tstep_d     = tstep_q;
        mem_d       = mem_q;
        cur_d       = cur_q;
        w_fire      = 1'b0;
        w_mem_sel   = '0;
        w_cur_sel   = '0;

        for (int i = 0; i < N_NEURONS; i++) begin
            if (ptr_q == 4'(i)) begin
                w_mem_sel = mem_q[i];
                w_cur_sel = cur_q[i];
            end
        end

        // Leak then integrate; the 9-bit sum saturates to 8 bits
        w_leak_sum = {1'b0, w_cur_sel} + {1'b0, (w_mem_sel >> BETA_SHIFT)};
        w_mem_new  = w_leak_sum[8] ? 8'hFF : w_leak_sum[7:0];

        case (fsm_q)
            S_IDLE: begin
                if (bus.start) begin
                    fsm_d    = S_UPDATE;
                    ptr_d    = '0;
                    shadow_d = '0;
                end
            end
            S_UPDATE: begin
                w_fire = (w_mem_sel >= c_THRESH);
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (ptr_q == 4'(i)) begin
                        mem_d[i]    = w_fire ? w_cur_sel : w_mem_new;
                        shadow_d[i] = w_fire;
                    end
                end
                if (ptr_q == c_LAST) begin
                    fsm_d       = S_DONE;
                    ptr_d       = '0;
                    spike_vec_d = shadow_d;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            S_DONE: begin
                fsm_d   = S_IDLE;
                tstep_d = tstep_q + 8'd1;
            end
            default: begin
                fsm_d = S_IDLE;
                ptr_d = '0;
            end
        endcase

        // Applied after the update so a colliding write lands next timestep
        for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.wr_en && (bus.wr_addr == 4'(i))) begin
                cur_d[i] = bus.wr_data;
            end
        end
    end

    always_comb begin
        w_rd_state = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.rd_addr == 4'(i)) begin
                w_rd_state = mem_q[i];
            end
        end
    end

    assign bus.busy        = (fsm_q == S_UPDATE) || (fsm_q == S_DONE);
    assign bus.done        = (fsm_q == S_DONE);
    assign bus.spike_valid = w_fire;
    assign bus.spike_id    = (fsm_q == S_UPDATE) ? ptr_q : 4'd0;
    assign bus.spike_vec   = spike_vec_q;
    assign bus.rd_state    = w_rd_state;
    assign bus.tstep       = tstep_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_scheduler
// Brief    : Self-checking bench for lif_scheduler against a timestep-level model.
// Revision : 1.0
// ============================================================================
module tb_lif_scheduler;

    localparam int N  = 4;
    localparam int TH = 200;
    localparam int BS = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lif_scheduler_if #(.N_NEURONS(N)) bus ();

    lif_scheduler #(
        .N_NEURONS  (N),
        .THRESHOLD  (TH),
        .BETA_SHIFT (BS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: membrane, current, fire flags, and position within a timestep
    // (-1 idle, 0..N-1 neuron being updated, N the completion cycle).
    int m_st [N];
    int m_cur[N];
    int m_sh [N];
    int m_vec;
    int m_tstep;
    int m_phase;
    int cur_ra;
    logic [31:0] obs_sv;
    logic [31:0] obs_sid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_cur[i] = 0; m_sh[i] = 0;
        end
        m_vec = 0; m_tstep = 0; m_phase = -1;
    endtask

    task automatic model_step(input logic st, input logic we, input int wa, input int wd);
        int k;
        int sum;
        if (m_phase < 0) begin
            if (st) m_phase = 0;
        end else if (m_phase < N) begin
            k = m_phase;
            m_sh[k] = (m_st[k] >= TH) ? 1 : 0;
            sum = m_cur[k] + (m_st[k] / (1 << BS));
            m_st[k] = m_sh[k] ? m_cur[k] : ((sum > 255) ? 255 : sum);
            m_phase++;
            if (m_phase == N) begin
                m_vec = 0;
                for (int i = 0; i < N; i++) m_vec += m_sh[i] << i;
            end
        end else begin
            m_tstep = (m_tstep + 1) % 256;
            m_phase = -1;
        end
        if (we && wa < N) m_cur[wa] = wd;
    endtask

    task automatic check_outputs();
        int upd;
        int exp_sv;
        upd    = (m_phase >= 0 && m_phase < N) ? 1 : 0;
        exp_sv = upd ? ((m_st[m_phase] >= TH) ? 1 : 0) : 0;
        obs_sv  = 32'(bus.spike_valid);
        obs_sid = 32'(bus.spike_id);
        chk("busy",        32'(bus.busy), (m_phase >= 0) ? 1 : 0);
        chk("done",        32'(bus.done), (m_phase == N) ? 1 : 0);
        chk("spike_valid", obs_sv, exp_sv);
        chk("spike_id",    obs_sid, upd ? m_phase : 0);
        chk("spike_vec",   32'(bus.spike_vec), m_vec);
        chk("tstep",       32'(bus.tstep), m_tstep);
        chk("rd_state",    32'(bus.rd_state), (cur_ra < N) ? m_st[cur_ra] : 0);
    endtask

    task automatic cyc(input logic st, input logic we, input int wa, input int wd, input int ra);
        @(negedge clk);
        bus.start   = st;
        bus.wr_en   = we;
        bus.wr_addr = 4'(wa);
        bus.wr_data = 8'(wd);
        bus.rd_addr = 4'(ra);
        cur_ra      = ra;
        #1;
        check_outputs();
        model_step(st, we, wa, wd);
        @(posedge clk);
    endtask

    task automatic timestep();
        cyc(1'b1, 1'b0, 0, 0, 0);
        repeat (N + 1) cyc(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic peek(input string tag, input int ra, input int exp);
        bus.rd_addr = 4'(ra);
        #1;
        chk(tag, 32'(bus.rd_state), exp);
    endtask

    int t0;

    initial begin
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.rd_addr = '0;
        cur_ra = 0;
        model_reset();

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Integration; start honoured on the first edge after release
        cyc(1'b1, 1'b1, 0, 60, 0);
        repeat (N + 1) cyc(1'b0, 1'b0, 0, 0, 0);
        peek("integ_s1", 0, 60);
        timestep(); peek("integ_s2", 0, 90);
        timestep(); peek("integ_s3", 0, 105);
        timestep(); peek("integ_s4", 0, 112);
        chk("integ_tstep", 32'(bus.tstep), 4);
        chk("integ_vec", 32'(bus.spike_vec), 0);

        // Firing
        cyc(1'b0, 1'b1, 1, 150, 0);
        timestep(); peek("fire_s1", 1, 150);
        timestep(); peek("fire_s2", 1, 225);
        cyc(1'b1, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 1);
        chk("fire_valid", obs_sv, 1);
        chk("fire_id", obs_sid, 1);
        repeat (N - 1) cyc(1'b0, 1'b0, 0, 0, 0);
        peek("fire_reload", 1, 150);
        chk("fire_vec", 32'(bus.spike_vec), 32'b0010);

        // Saturation
        cyc(1'b0, 1'b1, 2, 133, 0);
        timestep(); timestep();
        peek("sat_pre", 2, 199);
        cyc(1'b0, 1'b1, 2, 255, 0);
        timestep();
        peek("sat_post", 2, 255);

        // Start while busy is dropped
        t0 = m_tstep;
        cyc(1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 0, 0, 0);
        repeat (N) cyc(1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 0);
        chk("drop_tstep", 32'(bus.tstep), 32'((t0 + 1) % 256));
        chk("drop_idle", 32'(bus.busy), 0);

        // Reset in the middle of a timestep
        cyc(1'b1, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_sv",    32'(bus.spike_valid), 0);
        chk("rst_sid",   32'(bus.spike_id), 0);
        chk("rst_vec",   32'(bus.spike_vec), 0);
        chk("rst_tstep", 32'(bus.tstep), 0);
        for (int i = 0; i < N; i++) peek("rst_state", i, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        timestep();
        for (int i = 0; i < N; i++) peek("rst_clean", i, 0);

        // Write collision with the neuron being updated
        cyc(1'b0, 1'b1, 3, 10, 0);
        cyc(1'b1, 1'b0, 0, 0, 0);
        repeat (3) cyc(1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b1, 3, 100, 3);
        cyc(1'b0, 1'b0, 0, 0, 3);
        peek("coll_old", 3, 10);
        timestep();
        peek("coll_new", 3, 105);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
